// File: rtl/sha_trailer_verify_pkg.sv
// Shared types for the SHA-512 trailer verifier.
// Optional SHA_VERIFY_STATS_EN adds pass/fail counters in the top.
package sha_verify_pkg;

  localparam int DIG_BITS = 512;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    FLUSH,
    WAIT_DIG,
    REPORT
  } state_t;

  typedef struct packed {
    logic pass;
    logic err_empty;
    logic err_keep;
  } sts_t;

endpackage

// File: rtl/sha_trailer_verify_if.sv
// AXI-stream bundle used for host, hash and digest channels.
// Optional SHA_VERIFY_STATS_EN does not affect this interface.
interface sha_trailer_verify_if #(
  parameter int DATA_BITS = 512,
  parameter int ID_BITS   = 6
);

  logic                   tvalid;
  logic                   tready;
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic [ID_BITS-1:0]     tid;
  logic                   tlast;

  modport master (
    output tvalid, tdata, tkeep, tid, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tid, tlast,
    output tready
  );

endinterface

// File: rtl/sha_trailer_verify_fork.sv
// 1-to-2 stream broadcast with per-branch sent flags.
// Optional SHA_VERIFY_STATS_EN does not affect this module.
module sha_verify_fork
  import sha_verify_pkg::*;
#(
  parameter int DATA_BITS = 512,
  parameter int ID_BITS   = 6
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   in_valid,
  input  logic [DATA_BITS-1:0]   in_data,
  input  logic [DATA_BITS/8-1:0] in_keep,
  input  logic [ID_BITS-1:0]     in_id,
  input  logic                   in_last,
  output logic                   in_free,
  sha_trailer_verify_if.master   host,
  sha_trailer_verify_if.master   hash
);

  logic sent_h;
  logic sent_x;
  logic done_h;
  logic done_x;

  assign host.tvalid = in_valid & ~sent_h;
  assign host.tdata  = in_data;
  assign host.tkeep  = in_keep;
  assign host.tid    = in_id;
  assign host.tlast  = in_last;

  assign hash.tvalid = in_valid & ~sent_x;
  assign hash.tdata  = in_data;
  assign hash.tkeep  = in_keep;
  assign hash.tid    = in_id;
  assign hash.tlast  = in_last;

  // a branch is done if it already took the beat or takes it now
  assign done_h  = sent_h | (host.tvalid & host.tready);
  assign done_x  = sent_x | (hash.tvalid & hash.tready);
  assign in_free = in_valid & done_h & done_x;

  always_ff @(posedge clk) begin
    if (areset) begin
      sent_h <= 1'b0;
      sent_x <= 1'b0;
    end else if (in_free) begin
      sent_h <= 1'b0;
      sent_x <= 1'b0;
    end else if (in_valid) begin
      sent_h <= done_h;
      sent_x <= done_x;
    end
  end

endmodule

// File: rtl/sha_trailer_verify.sv
// Strips and checks a SHA-512 trailer beat, forwards payload to host and hash.
// Define SHA_VERIFY_STATS_EN for stat_pass_cnt / stat_fail_cnt outputs.
module sha_trailer_verify
  import sha_verify_pkg::*;
#(
  parameter int DATA_BITS = 512,
  parameter int ID_BITS   = 6,
  parameter int CNT_BITS  = 16
) (
  input  logic                aclk,
  input  logic                areset,
  sha_trailer_verify_if.slave  s_axis_host,
  sha_trailer_verify_if.master m_axis_host,
  sha_trailer_verify_if.master m_axis_hash,
  sha_trailer_verify_if.slave  s_axis_dig,
  output logic                sts_valid,
  input  logic                sts_ready,
  output logic                sts_pass,
  output logic                sts_err_empty,
  output logic                sts_err_keep,
  output logic [ID_BITS-1:0]  sts_id,
  output logic [CNT_BITS-1:0] sts_beats
`ifdef SHA_VERIFY_STATS_EN
  ,
  output logic [31:0]         stat_pass_cnt,
  output logic [31:0]         stat_fail_cnt
`endif
);

  localparam int KEEP_BITS = DATA_BITS / 8;

  state_t                state;
  sts_t                  flags;
  logic                  rdy_en;
  logic [DATA_BITS-1:0]  pend_data;
  logic [KEEP_BITS-1:0]  pend_keep;
  logic [ID_BITS-1:0]    pend_id;
  logic                  hold_vld;
  logic [DATA_BITS-1:0]  hold_data;
  logic [KEEP_BITS-1:0]  hold_keep;
  logic [ID_BITS-1:0]    hold_id;
  logic                  hold_last;
  logic                  hold_free;
  logic [DIG_BITS-1:0]   trailer;
  logic [ID_BITS-1:0]    id_q;
  logic [CNT_BITS-1:0]   beats_q;
  logic                  in_ok;
  logic                  in_fire;
  logic                  dig_fire;
  logic                  host_fire;
  logic                  dig_unused;

  sha_verify_fork #(
    .DATA_BITS (DATA_BITS),
    .ID_BITS   (ID_BITS)
  ) u_fork (
    .clk      (aclk),
    .areset   (areset),
    .in_valid (hold_vld),
    .in_data  (hold_data),
    .in_keep  (hold_keep),
    .in_id    (hold_id),
    .in_last  (hold_last),
    .in_free  (hold_free),
    .host     (m_axis_host),
    .hash     (m_axis_hash)
  );

  // pend holds the newest beat until its successor tells us its tlast
  assign in_ok = rdy_en
               & ((state == IDLE) | (state == PAYLOAD))
               & (~hold_vld | hold_free);

  assign s_axis_host.tready = in_ok;
  assign in_fire   = s_axis_host.tvalid & in_ok;
  assign s_axis_dig.tready  = (state == WAIT_DIG);
  assign dig_fire  = s_axis_dig.tvalid & (state == WAIT_DIG);
  assign host_fire = m_axis_host.tvalid & m_axis_host.tready;

  assign dig_unused = ^{s_axis_dig.tkeep, s_axis_dig.tid,
                        s_axis_dig.tlast};

  assign sts_valid     = (state == REPORT);
  assign sts_pass      = flags.pass;
  assign sts_err_empty = flags.err_empty;
  assign sts_err_keep  = flags.err_keep;
  assign sts_id        = id_q;
  assign sts_beats     = beats_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      flags     <= '0;
      rdy_en    <= 1'b0;
      pend_data <= '0;
      pend_keep <= '0;
      pend_id   <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
      hold_keep <= '0;
      hold_id   <= '0;
      hold_last <= 1'b0;
      trailer   <= '0;
      id_q      <= '0;
      beats_q   <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (hold_free)
        hold_vld <= 1'b0;
      if (host_fire && !(&beats_q))
        beats_q <= beats_q + 1'b1;
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            id_q <= s_axis_host.tid;
            if (s_axis_host.tlast) begin
              flags.err_empty <= 1'b1;
              flags.err_keep  <= ~&s_axis_host.tkeep;
              trailer <= s_axis_host.tdata[DIG_BITS-1:0];
              state   <= REPORT;
            end else begin
              pend_data <= s_axis_host.tdata;
              pend_keep <= s_axis_host.tkeep;
              pend_id   <= s_axis_host.tid;
              state     <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (in_fire) begin
            hold_vld  <= 1'b1;
            hold_data <= pend_data;
            hold_keep <= pend_keep;
            hold_id   <= pend_id;
            hold_last <= s_axis_host.tlast;
            if (s_axis_host.tlast) begin
              flags.err_keep <= ~&s_axis_host.tkeep;
              trailer <= s_axis_host.tdata[DIG_BITS-1:0];
              state   <= FLUSH;
            end else begin
              pend_data <= s_axis_host.tdata;
              pend_keep <= s_axis_host.tkeep;
              pend_id   <= s_axis_host.tid;
            end
          end
        end
        FLUSH: begin
          if (hold_free)
            state <= WAIT_DIG;
        end
        WAIT_DIG: begin
          if (dig_fire) begin
            flags.pass <=
              (s_axis_dig.tdata[DIG_BITS-1:0] == trailer)
              & ~flags.err_keep;
            state <= REPORT;
          end
        end
        REPORT: begin
          if (sts_ready) begin
            flags   <= '0;
            id_q    <= '0;
            beats_q <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHA_VERIFY_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_pass_cnt <= '0;
      stat_fail_cnt <= '0;
    end else if (sts_valid && sts_ready) begin
      if (sts_pass) begin
        if (!(&stat_pass_cnt))
          stat_pass_cnt <= stat_pass_cnt + 1'b1;
      end else begin
        if (!(&stat_fail_cnt))
          stat_fail_cnt <= stat_fail_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sha_trailer_verify.sv
// Directed bench for sha_trailer_verify; bench acts as the sha512 core.
// Build with SHA_VERIFY_STATS_EN to also check the stat counters.
module tb_sha_trailer_verify;
  import sha_verify_pkg::*;

  localparam int DB = 512;
  localparam int IB = 6;
  localparam int CB = 16;
  localparam logic [63:0] KALL = '1;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  sha_trailer_verify_if #(.DATA_BITS(DB), .ID_BITS(IB)) s_host ();
  sha_trailer_verify_if #(.DATA_BITS(DB), .ID_BITS(IB)) m_host ();
  sha_trailer_verify_if #(.DATA_BITS(DB), .ID_BITS(IB)) m_hash ();
  sha_trailer_verify_if #(.DATA_BITS(DB), .ID_BITS(IB)) s_dig ();

  logic          sts_valid;
  logic          sts_ready;
  logic          sts_pass;
  logic          sts_err_empty;
  logic          sts_err_keep;
  logic [IB-1:0] sts_id;
  logic [CB-1:0] sts_beats;
  logic          host_rdy;
  logic          hash_rdy;
`ifdef SHA_VERIFY_STATS_EN
  logic [31:0]   pass_cnt;
  logic [31:0]   fail_cnt;
`endif

  sha_trailer_verify #(
    .DATA_BITS (DB),
    .ID_BITS   (IB),
    .CNT_BITS  (CB)
  ) dut (
    .aclk          (clk),
    .areset        (areset),
    .s_axis_host   (s_host),
    .m_axis_host   (m_host),
    .m_axis_hash   (m_hash),
    .s_axis_dig    (s_dig),
    .sts_valid     (sts_valid),
    .sts_ready     (sts_ready),
    .sts_pass      (sts_pass),
    .sts_err_empty (sts_err_empty),
    .sts_err_keep  (sts_err_keep),
    .sts_id        (sts_id),
    .sts_beats     (sts_beats)
`ifdef SHA_VERIFY_STATS_EN
    ,
    .stat_pass_cnt (pass_cnt),
    .stat_fail_cnt (fail_cnt)
`endif
  );

  assign m_host.tready = host_rdy;
  assign m_hash.tready = hash_rdy;

  typedef struct {
    logic [DB-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    int          npay;
    logic [5:0]  id;
    bit          flip;
    logic [63:0] tkeep;
    int          stall;
    bit          e_pass;
    bit          e_empty;
    bit          e_keep;
  } vec_t;

  beat_t host_q[$];
  beat_t hash_q[$];
  vec_t  vecs[6];
  int    tests = 0;
  int    fails = 0;

  always @(negedge clk) begin
    if (!areset) begin
      if (m_host.tvalid && m_host.tready)
        host_q.push_back('{m_host.tdata, m_host.tlast});
      if (m_hash.tvalid && m_hash.tready)
        hash_q.push_back('{m_hash.tdata, m_hash.tlast});
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // stand-in for the external sha512 core: a rotate/xor fold
  function automatic logic [DB-1:0] fold(input logic [DB-1:0] q[$]);
    logic [DB-1:0] h;
    h = {8{64'h0123_4567_89AB_CDEF}};
    foreach (q[i]) h = {h[DB-2:0], h[DB-1]} ^ q[i];
    return h;
  endfunction

  task automatic send_beat(input logic [DB-1:0] d,
                           input logic [63:0] k,
                           input logic [5:0] id,
                           input logic last);
    int n;
    s_host.tvalid = 1'b1;
    s_host.tdata  = d;
    s_host.tkeep  = k;
    s_host.tid    = id;
    s_host.tlast  = last;
    n = 0;
    @(negedge clk);
    while (!s_host.tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_host.tready) begin
      tests++;
      fails++;
      $display("FAIL in_timeout: tready %0b, required 1", s_host.tready);
    end
    @(posedge clk);
    #1 s_host.tvalid = 1'b0;
  endtask

  task automatic wait_dig_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_dig.tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = s_dig.tready;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL dig_timeout: tready 0, required 1");
    end
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    logic [DB-1:0] sent[$];
    logic [DB-1:0] hq[$];
    logic [DB-1:0] d;
    logic [DB-1:0] trl;
    bit ok;
    int n;
    host_q.delete();
    hash_q.delete();
    for (int i = 0; i < v.npay; i++) begin
      d = {16{32'(vi * 16 + i + 1)}};
      d[DB-1 -: 32] = d[DB-1 -: 32] ^ 32'hCAFE_F00D;
      sent.push_back(d);
    end
    trl = fold(sent);
    trl[0] = trl[0] ^ v.flip;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < v.npay; i++)
          send_beat(sent[i], KALL, v.id, 1'b0);
        send_beat(trl, v.tkeep, v.id, 1'b1);
      end
      begin
        if (v.stall > 0) begin
          hash_rdy = 1'b0;
          repeat (5) @(posedge clk);
          @(negedge clk);
          chk("stall_in_ready", 64'(s_host.tready), 64'd0);
          chk("stall_host_once", 64'(host_q.size()), 64'd1);
          repeat (v.stall - 5) @(posedge clk);
          #1 hash_rdy = 1'b1;
        end
      end
    join
    if (v.npay > 0) begin
      wait_dig_ready(ok);
      if (ok) begin
        foreach (hash_q[i]) hq.push_back(hash_q[i].d);
        s_dig.tvalid = 1'b1;
        s_dig.tdata  = fold(hq);
        @(posedge clk);
        #1 s_dig.tvalid = 1'b0;
      end
    end
    n = 0;
    @(negedge clk);
    while (!sts_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_sts_valid", vi), 64'(sts_valid), 64'd1);
    chk($sformatf("v%0d_pass", vi), 64'(sts_pass), 64'(v.e_pass));
    chk($sformatf("v%0d_err_empty", vi),
        64'(sts_err_empty), 64'(v.e_empty));
    chk($sformatf("v%0d_err_keep", vi),
        64'(sts_err_keep), 64'(v.e_keep));
    chk($sformatf("v%0d_id", vi), 64'(sts_id), 64'(v.id));
    chk($sformatf("v%0d_beats", vi), 64'(sts_beats), 64'(v.npay));
    chk($sformatf("v%0d_host_cnt", vi),
        64'(host_q.size()), 64'(v.npay));
    chk($sformatf("v%0d_hash_cnt", vi),
        64'(hash_q.size()), 64'(v.npay));
    for (int i = 0; i < v.npay && i < host_q.size(); i++) begin
      chk($sformatf("v%0d_host_d%0d", vi, i),
          64'(host_q[i].d == sent[i]), 64'd1);
      chk($sformatf("v%0d_host_l%0d", vi, i),
          64'(host_q[i].l), 64'(i == v.npay - 1));
    end
    for (int i = 0; i < v.npay && i < hash_q.size(); i++) begin
      chk($sformatf("v%0d_hash_d%0d", vi, i),
          64'(hash_q[i].d == sent[i]), 64'd1);
      chk($sformatf("v%0d_hash_l%0d", vi, i),
          64'(hash_q[i].l), 64'(i == v.npay - 1));
    end
    sts_ready = 1'b1;
    @(posedge clk);
    #1 sts_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_sts_drop", vi), 64'(sts_valid), 64'd0);
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clk);
    chk({tag, "_sts_valid"}, 64'(sts_valid), 64'd0);
    chk({tag, "_in_ready0"}, 64'(s_host.tready), 64'd0);
    chk({tag, "_host_valid"}, 64'(m_host.tvalid), 64'd0);
    chk({tag, "_hash_valid"}, 64'(m_hash.tvalid), 64'd0);
    chk({tag, "_dig_ready"}, 64'(s_dig.tready), 64'd0);
    chk({tag, "_beats"}, 64'(sts_beats), 64'd0);
    @(negedge clk);
    chk({tag, "_in_ready1"}, 64'(s_host.tready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0] = '{npay:3, id:6'd1, flip:1'b0, tkeep:KALL, stall:0,
                e_pass:1'b1, e_empty:1'b0, e_keep:1'b0};
    vecs[1] = '{npay:3, id:6'd2, flip:1'b1, tkeep:KALL, stall:0,
                e_pass:1'b0, e_empty:1'b0, e_keep:1'b0};
    vecs[2] = '{npay:0, id:6'd5, flip:1'b0, tkeep:KALL, stall:0,
                e_pass:1'b0, e_empty:1'b1, e_keep:1'b0};
    vecs[3] = '{npay:2, id:6'd9, flip:1'b0, tkeep:KALL, stall:6,
                e_pass:1'b1, e_empty:1'b0, e_keep:1'b0};
    vecs[4] = '{npay:3, id:6'd12, flip:1'b0,
                tkeep:64'hFFFF_FFFF_FFFF_FFFE, stall:0,
                e_pass:1'b0, e_empty:1'b0, e_keep:1'b1};
    vecs[5] = '{npay:1, id:6'd33, flip:1'b0, tkeep:KALL, stall:0,
                e_pass:1'b1, e_empty:1'b0, e_keep:1'b0};

    s_host.tvalid = 1'b0;
    s_host.tdata  = '0;
    s_host.tkeep  = '0;
    s_host.tid    = '0;
    s_host.tlast  = 1'b0;
    s_dig.tvalid  = 1'b0;
    s_dig.tdata   = '0;
    s_dig.tkeep   = '1;
    s_dig.tid     = '0;
    s_dig.tlast   = 1'b1;
    sts_ready     = 1'b0;
    host_rdy      = 1'b1;
    hash_rdy      = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(s_host.tready), 64'd0);
    chk("rst_sts_id", 64'(sts_id), 64'd0);
    @(posedge clk);
    #1 areset = 1'b0;
    reset_checks("init");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // abandon a packet while the verifier waits for the digest
    @(posedge clk);
    #1;
    send_beat({16{32'h1357_9BDF}}, KALL, 6'd7, 1'b0);
    send_beat({16{32'h2468_ACE0}}, KALL, 6'd7, 1'b1);
    wait_dig_ready(ok);
    @(posedge clk);
    #1 areset = 1'b1;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    reset_checks("mid");

    run_vec(vecs[5], 5);
`ifdef SHA_VERIFY_STATS_EN
    chk("stat_pass_cnt", 64'(pass_cnt), 64'd1);
    chk("stat_fail_cnt", 64'(fail_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
